// File: rtl/sw_pkg.sv
// Shared definitions for the packet-buffer SRAM read path: widths, FSM encoding
// and the EOP empty-byte helper.
package sw_pkg;
  localparam int SRAM_ADDR_W    = 14;
  localparam int SRAM_DATA_W    = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int DESC_ADDR_W    = SRAM_ADDR_W;
  localparam int DESC_LEN_W     = 12;
  localparam int EMPTY_W        = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // Unused high-order bytes in the final word: (4 - len[1:0]) mod 4.
  function automatic logic [EMPTY_W-1:0] last_word_empty(input logic [1:0] len_lsb);
    return 2'd0 - len_lsb;
  endfunction
endpackage

// File: rtl/sram_rd_ctrl_if.sv
// Descriptor, SRAM port-B and egress stream signals of the read controller.
// Handshakes: a transfer happens in a cycle where valid & ready are both 1;
// valid never waits on ready, and payload holds while valid=1 and ready=0.
interface sram_rd_ctrl_if import sw_pkg::*; #(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int LEN_W  = DESC_LEN_W
);
  logic              desc_valid;
  logic              desc_ready;
  logic [ADDR_W-1:0] desc_addr;
  logic [LEN_W-1:0]  desc_len;
  logic              cen_b;
  logic              wen_b;
  logic [DATA_W-1:0] bwen_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic [DATA_W-1:0] rdata_b;
  logic              data_valid;
  logic              data_ready;
  logic [DATA_W-1:0] data;
  logic              sop;
  logic              eop;
  logic [1:0]        empty;
  logic              done;
  logic              desc_err;

  modport master (
    input  desc_valid, desc_addr, desc_len, rdata_b, data_ready,
    output desc_ready, cen_b, wen_b, bwen_b, addr_b, wdata_b,
           data_valid, data, sop, eop, empty, done, desc_err
  );

  modport slave (
    output desc_valid, desc_addr, desc_len, rdata_b, data_ready,
    input  desc_ready, cen_b, wen_b, bwen_b, addr_b, wdata_b,
           data_valid, data, sop, eop, empty, done, desc_err
  );
endinterface

// File: rtl/sram_rd_fifo.sv
// First-word-fall-through FIFO holding returned SRAM words with their tags;
// the occupancy count feeds the read-issue credit check.
module sram_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // The issuing side reserves a slot before each read, so a push into a full FIFO is a bug.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !do_pop && (count == (AW+1)'(DEPTH))));
endmodule

// File: rtl/sram_rd_ctrl.sv
// Packet-buffer read initiator: turns a frame descriptor into sequential port-B
// reads and streams the words out with SOP/EOP/empty marking under backpressure.
module sram_rd_ctrl import sw_pkg::*; #(
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int DATA_W     = SRAM_DATA_W,
  parameter int LEN_W      = DESC_LEN_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  sram_rd_ctrl_if.master bus,
  output rd_state_e state_dbg
);
  localparam int WC_W    = LEN_W - 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = DATA_W + 4;

  rd_state_e         state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [WC_W-1:0]   words, idx, words_in;
  logic [LEN_W:0]    len_round;
  logic [1:0]        empty_last;
  logic              pend, pend_sop, pend_eop;
  logic [1:0]        pend_empty;
  logic              desc_err_q;
  logic              accept, issue, last_issue, desc_ready, done;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [ENTRY_W-1:0] head;

  assign len_round  = {1'b0, bus.desc_len} + (LEN_W+1)'(BYTES_PER_WORD - 1);
  assign words_in   = len_round[LEN_W:2];
  assign accept     = bus.desc_valid && desc_ready;
  assign last_issue = (idx == words - 1'b1);
  // A slot is reserved per issued read, counting the one still in flight.
  assign issue      = (state == ST_READ) && ((int'(fifo_count) + int'(pend)) < FIFO_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    desc_ready = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        desc_ready = 1'b1;
        if (bus.desc_valid && (bus.desc_len != '0)) state_nxt = ST_READ;
      end
      ST_READ: begin
        if (issue && last_issue) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pend && fifo_empty) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr   <= '0;
      words      <= '0;
      idx        <= '0;
      empty_last <= '0;
      pend       <= 1'b0;
      pend_sop   <= 1'b0;
      pend_eop   <= 1'b0;
      pend_empty <= '0;
      desc_err_q <= 1'b0;
    end else begin
      desc_err_q <= accept && (bus.desc_len == '0);
      pend       <= issue;
      if (accept && (bus.desc_len != '0)) begin
        cur_addr   <= bus.desc_addr;
        words      <= words_in;
        idx        <= '0;
        empty_last <= last_word_empty(bus.desc_len[1:0]);
      end
      if (issue) begin
        cur_addr   <= cur_addr + 1'b1;
        idx        <= idx + 1'b1;
        pend_sop   <= (idx == '0);
        pend_eop   <= last_issue;
        pend_empty <= last_issue ? empty_last : 2'd0;
      end
    end
  end

  sram_rd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pend),
    .push_data ({bus.rdata_b, pend_sop, pend_eop, pend_empty}),
    .pop       (bus.data_valid && bus.data_ready),
    .pop_data  (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.desc_ready = desc_ready;
  assign bus.cen_b      = !issue;
  assign bus.wen_b      = 1'b1;
  assign bus.bwen_b     = '1;
  assign bus.addr_b     = cur_addr;
  assign bus.wdata_b    = '0;
  assign bus.data_valid = !fifo_empty;
  assign bus.data       = head[ENTRY_W-1:4];
  assign bus.sop        = head[3];
  assign bus.eop        = head[2];
  assign bus.empty      = head[1:0];
  assign bus.done       = done;
  assign bus.desc_err   = desc_err_q;
  assign state_dbg      = state;
endmodule

// File: tb/tb_sram_rd_ctrl.sv
// Bench for sram_rd_ctrl: SRAM model, frame-level reference model and scoreboard.
module tb_sram_rd_ctrl;
  import sw_pkg::*;

  localparam int W = 36;

  typedef struct {
    logic [13:0] addr;
    logic [11:0] len;
    int          words;
    logic [1:0]  last_empty;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_rd_ctrl_if bus();
  rd_state_e state_dbg;

  sram_rd_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- SRAM model: data one cycle after cen_b=0 ----------------
  logic [31:0] mem [16384];
  always @(posedge clk) if (!bus.cen_b) bus.rdata_b <= mem[bus.addr_b];

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [13:0]   exp_addr_q[$];
  logic [W-1:0]  exp_word;
  logic [13:0]   exp_addr;
  logic [W-1:0]  cur_word, prev_word;
  logic          prev_stall = 1'b0;
  int outstanding = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int frame_words = 0;
  int cyc = 0;
  int first_pop = 0;
  int last_pop = 0;
  logic [1:0] last_empty = 2'd0;
  int ready_mode = 0;
  vec_t vecs[5];

  assign cur_word = {bus.data, bus.sop, bus.eop, bus.empty};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is ceil(len/4) words at consecutive wrapped addresses.
  task automatic add_frame(input logic [13:0] addr, input int len);
    int n = (len + 3) / 4;
    for (int i = 0; i < n; i++) begin
      logic [13:0] a = 14'((int'(addr) + i) % 16384);
      logic        e = (i == n - 1);
      exp_addr_q.push_back(a);
      exp_q.push_back({mem[a], (i == 0), e, e ? 2'(4 * n - len) : 2'd0});
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (outstanding >= 4) check("credit_hold", bus.cen_b, 1);
      if (prev_stall) check("stall_stable", {bus.data_valid, cur_word}, {1'b1, prev_word});
      if (!bus.cen_b) begin
        outstanding++;
        check("read_expected", exp_addr_q.size() > 0, 1);
        if (exp_addr_q.size() > 0) begin
          exp_addr = exp_addr_q.pop_front();
          check("read_addr", bus.addr_b, exp_addr);
        end
      end
      if (bus.data_valid && bus.data_ready) begin
        outstanding--;
        check("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_word = exp_q.pop_front();
          check("word", cur_word, exp_word);
        end
        if (frame_words == 0) first_pop = cyc;
        last_pop = cyc;
        last_empty = bus.empty;
        frame_words++;
      end
      if (bus.done) begin
        check("done_after_drain", exp_q.size(), 0);
        done_cnt++;
      end
      if (bus.desc_err) err_cnt++;
      prev_stall = bus.data_valid && !bus.data_ready;
      prev_word  = cur_word;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- drivers ----------------
  initial begin
    bus.data_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.data_ready = 1'b1;
        1:       bus.data_ready = 1'($urandom_range(0, 1));
        default: bus.data_ready = 1'b0;
      endcase
    end
  end

  task automatic start_desc(input logic [13:0] addr, input int len);
    int t = 0;
    @(posedge clk); #1;
    while (!bus.desc_ready && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("desc_ready_wait", bus.desc_ready, 1);
    add_frame(addr, len);
    frame_words = 0;
    bus.desc_valid = 1'b1;
    bus.desc_addr  = addr;
    bus.desc_len   = 12'(len);
    @(posedge clk); #1;
    bus.desc_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 4000) begin
      @(posedge clk);
      t++;
    end
    check("done_seen", done_cnt >= target, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cen_b"}, bus.cen_b, 1);
    check({tag, "_desc_ready"}, bus.desc_ready, 1);
    check({tag, "_addr_b"}, bus.addr_b, 0);
    check({tag, "_data_valid"}, bus.data_valid, 0);
    check({tag, "_sop_eop_empty"}, {bus.sop, bus.eop, bus.empty}, 0);
    check({tag, "_done_err"}, {bus.done, bus.desc_err}, 0);
    check({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base_done;
    int base_err;
    int len;
    logic [13:0] addr;

    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    bus.desc_valid = 1'b0;
    bus.desc_addr  = '0;
    bus.desc_len   = '0;
    vecs[0] = '{14'h0010, 12'd64, 16, 2'd0};
    vecs[1] = '{14'h0100, 12'd5,  2,  2'd3};
    vecs[2] = '{14'h0200, 12'd1,  1,  2'd3};
    vecs[3] = '{14'h3FFE, 12'd16, 4,  2'd0};
    vecs[4] = '{14'h0040, 12'd7,  2,  2'd1};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check("tie_wen_b", bus.wen_b, 1);
    check("tie_bwen_b", bus.bwen_b, 32'hFFFF_FFFF);
    check("tie_wdata_b", bus.wdata_b, 0);
    rst_n = 1'b1;

    // Directed frames, ready held high: latency, tags, wrap, back-to-back.
    ready_mode = 0;
    for (int i = 0; i < 5; i++) begin
      base_done = done_cnt;
      start_desc(vecs[i].addr, int'(vecs[i].len));
      if (i == 0) begin
        @(negedge clk); check("lat_first_issue", bus.cen_b, 0);
        @(negedge clk); check("lat_no_valid_yet", bus.data_valid, 0);
        @(negedge clk); check("lat_first_valid", bus.data_valid, 1);
      end
      wait_done(base_done + 1);
      repeat (3) @(posedge clk);
      check("vec_words", frame_words, vecs[i].words);
      check("vec_last_empty", last_empty, vecs[i].last_empty);
      check("vec_back_to_back", last_pop - first_pop, vecs[i].words - 1);
      check("vec_single_done", done_cnt, base_done + 1);
    end

    // Zero-length descriptor.
    base_err = err_cnt;
    base_done = done_cnt;
    start_desc(14'h0500, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("zero_len_no_read", bus.cen_b, 1);
      check("zero_len_ready", bus.desc_ready, 1);
    end
    check("zero_len_err_pulse", err_cnt, base_err + 1);
    check("zero_len_no_data", frame_words, 0);
    check("zero_len_no_done", done_cnt, base_done);

    // Random backpressure with a long stall on a 32-word frame.
    ready_mode = 1;
    base_done = done_cnt;
    start_desc(14'h1234, 128);
    repeat (30) @(posedge clk);
    ready_mode = 2;
    repeat (20) @(posedge clk);
    #2;
    check("stall_outstanding", outstanding, 4);
    check("stall_no_issue", bus.cen_b, 1);
    ready_mode = 1;
    wait_done(base_done + 1);
    repeat (2) @(posedge clk);
    check("stall_frame_words", frame_words, 32);

    // Random frames under random backpressure.
    for (int k = 0; k < 6; k++) begin
      len  = int'($urandom_range(1, 200));
      addr = 14'($urandom_range(0, 16383));
      base_done = done_cnt;
      start_desc(addr, len);
      wait_done(base_done + 1);
      repeat (2) @(posedge clk);
      check("rand_frame_words", frame_words, (len + 3) / 4);
    end

    // Reset while the 5th word of a 32-word frame is presented.
    ready_mode = 0;
    start_desc(14'h0800, 128);
    begin
      int t = 0;
      while (frame_words < 4 && t < 200) begin
        @(posedge clk);
        t++;
      end
    end
    check("mid_rst_reached_word5", frame_words, 4);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    outstanding = 0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base_done = done_cnt;
    repeat (3) @(posedge clk);
    check("mid_rst_no_done", done_cnt, base_done);
    start_desc(14'h0900, 20);
    wait_done(base_done + 1);
    repeat (2) @(posedge clk);
    check("post_rst_words", frame_words, 5);
    check("post_rst_last_empty", last_empty, 0);
    check("post_rst_queue_empty", exp_q.size() + exp_addr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_rd_ctrl.md
Name: sram_rd_ctrl

Overview:
- Read-side initiator for the shared 32-bit packet-buffer SRAM (dual-port 16K x 32); drives the read port (port B) only.
- Accepts a frame descriptor (start word address, byte length) from the output-queue scheduler.
- Issues sequential SRAM reads and streams the frame out as 32-bit words with SOP/EOP/empty-byte marking and valid/ready backpressure.
- Sits between the packet buffer and the egress MAC TX path.

Parameters:
- ADDR_W, 14, SRAM word-address width; the address wraps modulo 2^ADDR_W.
- DATA_W, 32, SRAM and stream data width; fixed at 32.
- LEN_W, 12, descriptor byte-length width (max 4095 bytes).
- FIFO_DEPTH, 4, output buffer entries; power of 2, minimum 4.

Ports:
- iClk  in  1  system clock
- iRst_n  in  1  reset, active-low
- iDescValid  in  1  descriptor valid
- oDescReady  out  1  descriptor accepted when iDescValid & oDescReady
- iDescAddr  in  ADDR_W  first word address of the frame
- iDescLen  in  LEN_W  frame length in bytes
- oCEnB  out  1  SRAM chip enable, active-low
- oWEnB  out  1  SRAM write enable, active-low; tied 1 (read only)
- oBWEnB  out  DATA_W  SRAM bit write enable; tied all-1
- oAddrB  out  ADDR_W  SRAM read address
- oWDataB  out  DATA_W  tied 0
- iRDataB  in  DATA_W  SRAM read data, valid one cycle after oCEnB=0
- oDataValid  out  1  stream word valid
- iDataReady  in  1  stream sink ready
- oData  out  DATA_W  stream word; byte 0 in [7:0]
- oSop  out  1  first word of frame
- oEop  out  1  last word of frame
- oEmpty  out  2  invalid high-order bytes in the EOP word; 0 on non-EOP words
- oDone  out  1  one-cycle pulse when the frame is fully drained
- oDescErr  out  1  one-cycle pulse when a zero-length descriptor is consumed

Behaviour:
- Reset: iRst_n is asynchronous, active-low, single clock iClk.
  - On reset: state IDLE, oDescReady=1, oCEnB=1, oAddrB=0, oDataValid=0, oSop/oEop/oEmpty/oDone/oDescErr=0.
  - FIFO cleared, in-flight flag cleared.
- FSM IDLE:
  - oDescReady=1.
  - On accept with len>0: latch addr; words=ceil(len/4); emptyLast=(4-len[1:0])&3; go to READ.
  - On accept with len=0: pulse oDescErr next cycle, no SRAM access, stay in IDLE.
- FSM READ:
  - oDescReady=0.
  - Issue a read (oCEnB=0, oAddrB=cur) in any cycle where FIFO occupancy + in-flight < FIFO_DEPTH.
  - cur increments by 1 per issue and wraps from 2^ADDR_W-1 to 0.
  - After the last word is issued, go to DRAIN.
- FSM DRAIN:
  - Wait until the in-flight read has landed and the FIFO is empty, then pulse oDone for one cycle and go to IDLE.
  - The next descriptor is accepted no earlier than the cycle after the oDone pulse.
- Read return: iRDataB is captured in the cycle after issue and pushed to the FIFO with sop/eop/empty tags. The sop tag is set on word index 0; the eop tag on index words-1. A 1-word frame has both sop and eop set.
- FIFO output: first-word-fall-through.
  - oData/oSop/oEop/oEmpty are stable while oDataValid=1 and iDataReady=0.
  - A pop occurs on oDataValid & iDataReady.
- Latency: descriptor accept in cycle T → first oCEnB=0 at T+1 → first oDataValid at T+3.
- Throughput: with iDataReady held high, one word per cycle, no bubbles.
- Credit rule: the occupancy+in-flight check guarantees no FIFO overflow under arbitrary backpressure.
  - Overflow is a design error; assert it in simulation.
- Simultaneous push and pop in the same cycle: occupancy is unchanged.
- Reset mid-frame: the frame is abandoned and no oDone is produced; the sink must discard the partial frame.

Decomposition:
- Shared package `sw_pkg`:
  - Constants: SRAM_ADDR_W=14, SRAM_DATA_W=32, BYTES_PER_WORD=4.
  - FSM state encoding: IDLE/READ/DRAIN.
  - Descriptor field widths.
- Sub-module `sram_rd_fifo`: synchronous FWFT FIFO (depth FIFO_DEPTH, width DATA_W+4) exposing a count output for the credit check.

Test Plan:
1. Descriptor addr=0x0010, len=64, iDataReady=1 → 16 words from addresses 0x0010–0x001F, back-to-back. oSop on word 0, oEop on word 15, oEmpty=0, single oDone pulse after the last pop.
2. len=5 at addr=0x0100 → 2 words; the second word has oEop=1 and oEmpty=3. len=1 → 1 word with oSop=oEop=1 and oEmpty=3.
3. addr=0x3FFE, len=16 → reads at 0x3FFE, 0x3FFF, 0x0000, 0x0001; data order preserved.
4. len=128 with iDataReady toggling randomly and held low for 20 cycles → no data loss or duplication, and no FIFO overflow. oCEnB stays 1 while occupancy + in-flight = 4.
5. len=0 → oDescErr pulses once, oCEnB stays 1, no oDataValid, oDescReady remains 1.
6. iRst_n asserted low on the 5th word of a 32-word frame → all outputs take reset values immediately. After release, a new descriptor is accepted and streamed correctly from its SOP.
